// File: rtl/mdu_iter_if.sv
// Request/result bundle between the ALU operand muxes, the hazard unit and mdu_iter.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, op, SrcA, SrcB, input busy, done, HI, LO);
  modport slave  (input start, op, SrcA, SrcB, output busy, done, HI, LO);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, owning the architectural HI/LO registers.
// Signed operations run on magnitudes; signs are restored in the FIX state.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  mdu_iter_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_r;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rem_r;    // product high half or running remainder
  logic [WIDTH-1:0]   q_r;      // multiplier/product low half or dividend/quotient
  logic               is_div_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               dz_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               signed_op_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [WIDTH-1:0]   step_rem_s;
  logic [WIDTH-1:0]   step_q_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rmd_fix_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  assign bus.busy = (state_r != IDLE);
  assign bus.done = done_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

  // Operand sign detection and magnitude extraction at the request port.
  always_comb begin
    signed_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg_s     = signed_op_s & bus.SrcA[WIDTH-1];
    b_neg_s     = signed_op_s & bus.SrcB[WIDTH-1];
    if (a_neg_s) begin
      a_abs_s = -bus.SrcA;
    end else begin
      a_abs_s = bus.SrcA;
    end
    if (b_neg_s) begin
      b_abs_s = -bus.SrcB;
    end else begin
      b_abs_s = bus.SrcB;
    end
  end

  // One shift-add or restoring shift-subtract step.
  always_comb begin
    mul_sum_s   = {1'b0, rem_r} + ({1'b0, a_r} & {(WIDTH+1){q_r[0]}});
    div_shift_s = {rem_r, q_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, a_r};
    if (is_div_r) begin
      if (div_diff_s[WIDTH] == 1'b0) begin
        step_rem_s = div_diff_s[WIDTH-1:0];
        step_q_s   = {q_r[WIDTH-2:0], 1'b1};
      end else begin
        step_rem_s = div_shift_s[WIDTH-1:0];
        step_q_s   = {q_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_rem_s = mul_sum_s[WIDTH:1];
      step_q_s   = {mul_sum_s[0], q_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes; a zero divisor forces an all-ones quotient.
  always_comb begin
    prod_s = {rem_r, q_r};
    if (neg_q_r) begin
      prod_fix_s = -prod_s;
      quo_fix_s  = -q_r;
    end else begin
      prod_fix_s = prod_s;
      quo_fix_s  = q_r;
    end
    if (dz_r) begin
      quo_fix_s = {WIDTH{1'b1}};
    end else begin
      quo_fix_s = quo_fix_s;
    end
    if (neg_r_r) begin
      rmd_fix_s = -rem_r;
    end else begin
      rmd_fix_s = rem_r;
    end
    if (is_div_r) begin
      fix_hi_s = rmd_fix_s;
      fix_lo_s = quo_fix_s;
    end else begin
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                a_r      <= a_abs_s;
                q_r      <= b_abs_s;
                rem_r    <= {WIDTH{1'b0}};
                cnt_r    <= {CNT_W{1'b0}};
                is_div_r <= 1'b0;
                neg_q_r  <= a_neg_s ^ b_neg_s;
                neg_r_r  <= 1'b0;
                dz_r     <= 1'b0;
                state_r  <= CALC;
              end
              OP_DIV, OP_DIVU: begin
                a_r      <= b_abs_s;
                q_r      <= a_abs_s;
                rem_r    <= {WIDTH{1'b0}};
                cnt_r    <= {CNT_W{1'b0}};
                is_div_r <= 1'b1;
                neg_q_r  <= a_neg_s ^ b_neg_s;
                neg_r_r  <= a_neg_s;
                dz_r     <= (bus.SrcB == {WIDTH{1'b0}});
                state_r  <= CALC;
              end
              OP_MTHI: hi_r <= bus.SrcA;
              OP_MTLO: lo_r <= bus.SrcA;
              default: state_r <= IDLE;
            endcase
          end
        end
        CALC: begin
          rem_r <= step_rem_s;
          q_r   <= step_q_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {CNT_W{1'b1}}) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
